// File: rtl/dcache_load_formatter.sv
// dcache_load_formatter: tags dCache requests, formats load responses, and
// buffers {tag, data} results in a small FIFO toward mem_unit writeback.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   req_*                  request issued to the dCache (records metadata)
//   kill_i, kill_tag_i     squash the outstanding request with that tag
//   rsp_*                  dCache response (no backpressure)
//   out_valid_o/ready_i    FIFO head handshake, out_tag_o/out_data_o payload
//   pending_o              number of live table entries
//   overflow_o             sticky: a response was lost to a full FIFO
//   protocol_err_o         one-cycle pulse: duplicate tag or orphan response
module dcache_load_formatter #(
    parameter int TAG_WIDTH  = 7,
    parameter int DATA_WIDTH = 64,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,
    input  logic [2:0]            req_addr_lo_i,
    input  logic [3:0]            req_mem_size_i,
    input  logic                  req_is_load_i,
    input  logic                  kill_i,
    input  logic [TAG_WIDTH-1:0]  kill_tag_i,
    input  logic                  rsp_valid_i,
    input  logic [TAG_WIDTH-1:0]  rsp_tag_i,
    input  logic [DATA_WIDTH-1:0] rsp_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [TAG_WIDTH-1:0]  out_tag_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [TAG_WIDTH:0]    pending_o,
    output logic                  overflow_o,
    output logic                  protocol_err_o
);

    localparam int ENTRIES = 1 << TAG_WIDTH;
    localparam int AW      = $clog2(OUT_DEPTH);

    typedef struct packed {
        logic [2:0] addr_lo;
        logic [3:0] size;
        logic       is_load;
    } meta_t;

    logic [ENTRIES-1:0]    valid_q;
    logic [ENTRIES-1:0]    killed_q;
    meta_t                 meta_q [ENTRIES];

    logic [TAG_WIDTH-1:0]  fifo_tag  [OUT_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data [OUT_DEPTH];
    logic [AW:0]           wr_q, rd_q;

    logic [TAG_WIDTH:0]    pending_q;
    logic                  overflow_q;
    logic                  err_q;

    meta_t                 rsp_meta;
    logic                  rsp_hit, rsp_orphan, rsp_drop, rsp_live;
    logic                  kill_hit, req_dup, req_inc;
    logic                  fifo_empty, fifo_full, pop, push, lost;
    logic [DATA_WIDTH-1:0] sh_b, sh_h, sh_w, fmt;
    logic                  full_w;

    assign rsp_meta   = meta_q[rsp_tag_i];
    assign rsp_hit    = rsp_valid_i && valid_q[rsp_tag_i];
    assign rsp_orphan = rsp_valid_i && !valid_q[rsp_tag_i];
    assign rsp_drop   = killed_q[rsp_tag_i] ||
                        (kill_i && kill_tag_i == rsp_tag_i);
    assign rsp_live   = rsp_hit && !rsp_drop;

    assign kill_hit   = kill_i && valid_q[kill_tag_i];

    // A response retiring the same tag frees the slot first, so the
    // request lands in a free entry: no error, pending nets to zero.
    assign req_inc = req_valid_i &&
                     (!valid_q[req_tag_i] ||
                      (rsp_hit && rsp_tag_i == req_tag_i));
    assign req_dup = req_valid_i && !req_inc;

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[AW] != rd_q[AW]) &&
                        (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop        = !fifo_empty && out_ready_i;
    assign push       = rsp_live && (!fifo_full || pop);
    assign lost       = rsp_live && fifo_full && !pop;

    assign sh_b   = rsp_data_i >> {rsp_meta.addr_lo, 3'b0};
    assign sh_h   = rsp_data_i >> {rsp_meta.addr_lo[2:1], 4'b0};
    assign sh_w   = rsp_data_i >> {rsp_meta.addr_lo[2], 5'b0};
    assign full_w = rsp_meta.size[3] || (rsp_meta.size[1:0] == 2'd3);

    always_comb begin
        fmt = '0;
        unique case (1'b1)
            !rsp_meta.is_load:
                fmt = '0;
            rsp_meta.is_load && full_w:
                fmt = rsp_data_i;
            rsp_meta.is_load && !full_w && rsp_meta.size[1:0] == 2'd0:
                fmt = {{(DATA_WIDTH-8){~rsp_meta.size[2] & sh_b[7]}},
                       sh_b[7:0]};
            rsp_meta.is_load && !full_w && rsp_meta.size[1:0] == 2'd1:
                fmt = {{(DATA_WIDTH-16){~rsp_meta.size[2] & sh_h[15]}},
                       sh_h[15:0]};
            rsp_meta.is_load && !full_w && rsp_meta.size[1:0] == 2'd2:
                fmt = {{(DATA_WIDTH-32){~rsp_meta.size[2] & sh_w[31]}},
                       sh_w[31:0]};
        endcase
    end

    // Order matters: kill, then response retire, then request install.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q    <= '0;
            killed_q   <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (kill_hit)
                killed_q[kill_tag_i] <= 1'b1;
            if (rsp_hit) begin
                valid_q[rsp_tag_i]  <= 1'b0;
                killed_q[rsp_tag_i] <= 1'b0;
            end
            if (req_valid_i) begin
                valid_q[req_tag_i]  <= 1'b1;
                killed_q[req_tag_i] <= 1'b0;
            end
            if (push)
                wr_q <= wr_q + 1'b1;
            if (pop)
                rd_q <= rd_q + 1'b1;
            if (lost)
                overflow_q <= 1'b1;
            pending_q <= pending_q
                       + (TAG_WIDTH+1)'(req_inc)
                       - (TAG_WIDTH+1)'(rsp_hit);
            err_q <= req_dup || rsp_orphan;
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_valid_i)
            meta_q[req_tag_i] <= '{addr_lo: req_addr_lo_i,
                                   size:    req_mem_size_i,
                                   is_load: req_is_load_i};
        if (push) begin
            fifo_tag[wr_q[AW-1:0]]  <= rsp_tag_i;
            fifo_data[wr_q[AW-1:0]] <= fmt;
        end
    end

    assign out_valid_o    = !fifo_empty;
    assign out_tag_o      = out_valid_o ? fifo_tag[rd_q[AW-1:0]] : '0;
    assign out_data_o     = out_valid_o ? fifo_data[rd_q[AW-1:0]] : '0;
    assign pending_o      = pending_q;
    assign overflow_o     = overflow_q;
    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_dcache_load_formatter.sv
// tb_dcache_load_formatter: scoreboard bench for dcache_load_formatter.
// Expected results queue on stimulus, compared as the FIFO pops.
module tb_dcache_load_formatter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [6:0]  req_tag = '0;
    logic [2:0]  req_lo = '0;
    logic [3:0]  req_size = '0;
    logic        req_ld = 1'b0;
    logic        kill = 1'b0;
    logic [6:0]  kill_tag = '0;
    logic        rsp_valid = 1'b0;
    logic [6:0]  rsp_tag = '0;
    logic [63:0] rsp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [6:0]  out_tag;
    logic [63:0] out_data;
    logic [7:0]  pending;
    logic        overflow;
    logic        perr;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [6:0]  tag;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    dcache_load_formatter dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_tag_i      (req_tag),
        .req_addr_lo_i  (req_lo),
        .req_mem_size_i (req_size),
        .req_is_load_i  (req_ld),
        .kill_i         (kill),
        .kill_tag_i     (kill_tag),
        .rsp_valid_i    (rsp_valid),
        .rsp_tag_i      (rsp_tag),
        .rsp_data_i     (rsp_data),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .out_tag_o      (out_tag),
        .out_data_o     (out_data),
        .pending_o      (pending),
        .overflow_o     (overflow),
        .protocol_err_o (perr)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        kill      = 1'b0;
        rsp_valid = 1'b0;
    endtask

    task automatic req(input logic [6:0] t, input logic [2:0] lo,
                       input logic [3:0] sz, input logic ld);
        req_valid = 1'b1;
        req_tag   = t;
        req_lo    = lo;
        req_size  = sz;
        req_ld    = ld;
    endtask

    task automatic rsp(input logic [6:0] t, input logic [63:0] d);
        rsp_valid = 1'b1;
        rsp_tag   = t;
        rsp_data  = d;
    endtask

    task automatic kil(input logic [6:0] t);
        kill     = 1'b1;
        kill_tag = t;
    endtask

    task automatic expect_out(input logic [6:0] t, input logic [63:0] d);
        sb.push_back('{tag: t, data: d});
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++)
            @(posedge clk);
        @(negedge clk);
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_out", {57'd0, out_tag}, 64'hFFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_tag", {57'd0, out_tag}, {57'd0, e.tag});
                chk("out_data", out_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        repeat (2) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_tag", {57'd0, out_tag}, 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_pending", {56'd0, pending}, 64'd0);
        chk("rst_ovf", {63'd0, overflow}, 64'd0);
        chk("rst_err", {63'd0, perr}, 64'd0);

        // signed byte
        req(7'd5, 3'd3, 4'b0000, 1'b1);
        step();
        @(negedge clk);
        chk("byte_pend1", {56'd0, pending}, 64'd1);
        rsp(7'd5, 64'h0000_0000_8000_0000);
        expect_out(7'd5, 64'hFFFF_FFFF_FFFF_FF80);
        step();
        @(negedge clk);
        chk("byte_pend0", {56'd0, pending}, 64'd0);
        drain();

        // unsigned then signed half
        req(7'd6, 3'd6, 4'b0101, 1'b1);
        step();
        rsp(7'd6, 64'hBEEF_0000_0000_0000);
        expect_out(7'd6, 64'h0000_0000_0000_BEEF);
        step();
        req(7'd6, 3'd6, 4'b0001, 1'b1);
        step();
        rsp(7'd6, 64'hBEEF_0000_0000_0000);
        expect_out(7'd6, 64'hFFFF_FFFF_FFFF_BEEF);
        step();
        drain();

        // kill before response, then kill with response
        req(7'd9, 3'd0, 4'b0011, 1'b1);
        step();
        kil(7'd9);
        step();
        rsp(7'd9, 64'h1111);
        step();
        @(negedge clk);
        chk("kill_pend", {56'd0, pending}, 64'd0);
        chk("kill_noout", {63'd0, out_valid}, 64'd0);
        req(7'd9, 3'd0, 4'b0011, 1'b1);
        step();
        kil(7'd9);
        rsp(7'd9, 64'h2222);
        step();
        @(negedge clk);
        chk("kill2_pend", {56'd0, pending}, 64'd0);
        chk("kill2_noout", {63'd0, out_valid}, 64'd0);
        chk("kill2_err", {63'd0, perr}, 64'd0);

        // backpressure and overflow
        out_ready = 1'b0;
        for (int t = 10; t < 15; t++) begin
            req(7'(t), 3'd0, 4'b0011, 1'b1);
            step();
        end
        for (int t = 10; t < 15; t++) begin
            rsp(7'(t), 64'hA5A5_0000_0000_0000 | 64'(t));
            if (t < 14)
                expect_out(7'(t), 64'hA5A5_0000_0000_0000 | 64'(t));
            step();
        end
        @(negedge clk);
        chk("bp_ovf", {63'd0, overflow}, 64'd1);
        chk("bp_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_head", {57'd0, out_tag}, 64'd10);
        chk("bp_pend", {56'd0, pending}, 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        chk("bp_empty", {63'd0, out_valid}, 64'd0);

        // orphan response
        rsp(7'd20, 64'h3333);
        step();
        @(negedge clk);
        chk("orphan_err", {63'd0, perr}, 64'd1);
        chk("orphan_noout", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        chk("orphan_pulse", {63'd0, perr}, 64'd0);

        // duplicate request (store)
        req(7'd3, 3'd0, 4'b0011, 1'b0);
        step();
        req(7'd3, 3'd0, 4'b0011, 1'b0);
        step();
        @(negedge clk);
        chk("dup_err", {63'd0, perr}, 64'd1);
        chk("dup_pend", {56'd0, pending}, 64'd1);
        rsp(7'd3, 64'hDEAD_BEEF_DEAD_BEEF);
        expect_out(7'd3, 64'd0);
        step();
        drain();

        // same-cycle retire and reinstall on tag 7
        req(7'd7, 3'd0, 4'b0011, 1'b1);
        step();
        rsp(7'd7, 64'h0123_4567_89AB_CDEF);
        req(7'd7, 3'd0, 4'b0010, 1'b1);
        expect_out(7'd7, 64'h0123_4567_89AB_CDEF);
        step();
        @(negedge clk);
        chk("same_err", {63'd0, perr}, 64'd0);
        chk("same_pend", {56'd0, pending}, 64'd1);
        rsp(7'd7, 64'h1234_5678_9ABC_DEF0);
        expect_out(7'd7, 64'hFFFF_FFFF_9ABC_DEF0);
        step();
        @(negedge clk);
        chk("same_pend0", {56'd0, pending}, 64'd0);
        drain();

        // reset mid-operation
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        req(7'd1, 3'd0, 4'b0011, 1'b1);
        step();
        req(7'd2, 3'd0, 4'b0011, 1'b1);
        step();
        req(7'd4, 3'd0, 4'b1000, 1'b1);
        step();
        rsp(7'd4, 64'h55);
        step();
        @(negedge clk);
        chk("pre_rst_pend", {56'd0, pending}, 64'd2);
        chk("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        @(negedge clk);
        chk("mr_valid", {63'd0, out_valid}, 64'd0);
        chk("mr_tag", {57'd0, out_tag}, 64'd0);
        chk("mr_data", out_data, 64'd0);
        chk("mr_pend", {56'd0, pending}, 64'd0);
        chk("mr_ovf", {63'd0, overflow}, 64'd0);
        chk("mr_err", {63'd0, perr}, 64'd0);
        rsp(7'd1, 64'h77);
        step();
        @(negedge clk);
        chk("mr_orphan", {63'd0, perr}, 64'd1);
        chk("mr_noout", {63'd0, out_valid}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_load_formatter.md
Name: dcache_load_formatter

Overview:
- Sits directly downstream of the dCache interface, on the path from dCache responses back to the CPU.
- Records per-tag metadata for every request the interface issues: byte offset, size, signedness, load/store.
- On each dCache response it extracts and extends the addressed field, drops responses for killed requests, and buffers results in a small FIFO toward the mem_unit writeback path.

Parameters:
- TAG_WIDTH, 7: request tag width; the table holds 2^TAG_WIDTH entries.
- DATA_WIDTH, 64: response and output data width.
- OUT_DEPTH, 4: output FIFO depth (power of 2, at least 2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request accepted by the dCache this cycle (core valid AND dCache ready).
- req_tag_i  in  TAG_WIDTH  tag (rd) of the issued request.
- req_addr_lo_i  in  3  address bits [2:0].
- req_mem_size_i  in  4  mem_size. [1:0]: 0 = byte, 1 = half, 2 = word, 3 = double. Bit2 = 1 means zero-extend. Bit3 = 1 means full width.
- req_is_load_i  in  1  1 = load, 0 = store/AMO-without-data.
- kill_i  in  1  kill the request carrying kill_tag_i.
- kill_tag_i  in  TAG_WIDTH  tag to kill.
- rsp_valid_i  in  1  dCache response valid. No backpressure is possible on this port.
- rsp_tag_i  in  TAG_WIDTH  response tag.
- rsp_data_i  in  DATA_WIDTH  raw 64-bit response word.
- out_valid_o  out  1  FIFO head valid.
- out_ready_i  in  1  consumer accepts the head.
- out_tag_o  out  TAG_WIDTH  head tag.
- out_data_o  out  DATA_WIDTH  formatted data. Always 0 for stores.
- pending_o  out  TAG_WIDTH+1  count of valid table entries.
- overflow_o  out  1  sticky: a response was dropped because the FIFO was full.
- protocol_err_o  out  1  one-cycle pulse on a duplicate request tag or a response with no matching entry.

Behaviour:
- Single clock domain. All state is reset synchronously while rst_i = 1.
- Reset values: all table entries invalid; FIFO empty; out_valid_o = 0; out_tag_o = 0; out_data_o = 0; pending_o = 0; overflow_o = 0; protocol_err_o = 0.
- Table entry fields: valid, killed, addr_lo[2:0], size[3:0], is_load.
- Request write:
  - On req_valid_i, the entry at req_tag_i is written with valid = 1, killed = 0, and the request fields.
  - If that entry was already valid: pulse protocol_err_o, overwrite the entry, leave pending_o unchanged.
- Kill:
  - On kill_i, if the entry at kill_tag_i is valid, set killed = 1.
  - If the entry is invalid, ignore the kill.
- Response handling, on rsp_valid_i, using the entry at rsp_tag_i as it stood before this cycle's updates:
  - Entry invalid: pulse protocol_err_o and drop the response.
  - Entry killed, or kill_i with kill_tag_i == rsp_tag_i in the same cycle: clear the entry and drop the response.
  - Otherwise: clear the entry and push {tag, formatted data} into the FIFO.
- Formatting, for loads only (stores push data 0):
  - byte: rsp_data_i >> {addr_lo, 3'b0}, field [7:0].
  - half: shift by {addr_lo[2:1], 4'b0}, field [15:0].
  - word: shift by {addr_lo[2], 5'b0}, field [31:0].
  - double, or size[3] = 1: pass through unchanged.
  - Sign-extend the field to 64 bits when size[2] = 0; zero-extend when size[2] = 1.
- Same-cycle request and response on the same tag: the response consumes the old entry, then the request installs the new entry. Net effect: entry valid with the new contents, pending_o unchanged.
- pending_o update per cycle: +1 for a request written to an invalid entry, -1 for each entry cleared by a response. Both may occur in the same cycle.
- FIFO:
  - Latency: a response in cycle N appears on out_* in cycle N+1 when the FIFO is empty. There is no combinational path from rsp_* to out_*.
  - Pop occurs when out_valid_o && out_ready_i.
  - Push while full is accepted only if a pop occurs in the same cycle.
  - Push while full with no pop: drop the response, clear its table entry, set overflow_o (held until reset).
  - out_* stay stable while out_valid_o = 1 and out_ready_i = 0.
  - Pointers wrap modulo OUT_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Reset asserted mid-operation: all pending entries and buffered results are discarded. No output is produced for them afterward.

Test Plan:
- Signed byte load: req tag 5, addr_lo 3, size 4'b0000, then rsp tag 5 with data 0x0000_0000_8000_0000 → next cycle out_tag_o = 5, out_data_o = 0xFFFF_FFFF_FFFF_FF80; pending_o goes 1 → 0.
- Unsigned half load: addr_lo 6, size 4'b0101, data 0xBEEF_0000_0000_0000 → out_data_o = 0x0000_0000_0000_BEEF. Same data with size 4'b0001 → 0xFFFF_FFFF_FFFF_BEEF.
- Kill: req tag 9, kill tag 9, rsp tag 9 → no out_valid_o, pending_o returns to 0. Kill and rsp on tag 9 in the same cycle → also dropped.
- Backpressure: out_ready_i = 0, five responses to five distinct live tags → first four buffered in order, fifth dropped, overflow_o = 1. Release out_ready_i → four pops in order, then out_valid_o = 0.
- Protocol errors: rsp tag 20 with no request → protocol_err_o pulses one cycle, no output. Two requests on tag 3 → pulse on the second, pending_o = 1.
- Same-cycle rsp (old) and req (new) on tag 7 → old result output, entry remains valid, pending_o unchanged. Assert rst_i with two entries pending → all outputs return to reset values.
